// File: rtl/philv_fetch_unit.sv
// PhilosophyV instruction-fetch front end with a DEPTH-entry prefetch queue.
// Optional stall counter output enabled by PHILV_FETCH_STALL_CNT_EN.
module philv_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rstb,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [31:0]     instr_data,
    output logic [XLEN-1:0] instr_pc
`ifdef PHILV_FETCH_STALL_CNT_EN
    ,
    output logic [31:0]     stall_cycles
`endif
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    // Wide enough for back-to-back redirects while memory still owes responses
    localparam int unsigned DW = CW + 2;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [31:0]     r_q_data [DEPTH];
    logic [DEPTH-1:0] r_filled;
    logic [AW-1:0]   r_alloc;
    logic [AW-1:0]   r_fill;
    logic [AW-1:0]   r_head;
    logic [CW-1:0]   r_occ;
    logic [CW-1:0]   r_outst;
    logic [DW-1:0]   r_drop;

    logic            w_req_valid;
    logic            w_alloc;
    logic            w_instr_valid;
    logic            w_pop;
    logic            w_fill;
    logic            w_discard;
    logic [CW-1:0]   w_occ_nxt;
    logic [CW-1:0]   w_outst_nxt;
    logic [DW-1:0]   w_drop_nxt;
    logic [DW-1:0]   w_flush_drop;

    assign w_req_valid   = (r_occ != FULL) && !redirect_valid;
    assign w_alloc       = w_req_valid && imem_req_ready;
    assign w_instr_valid = r_filled[r_head] && (r_occ != '0) && !redirect_valid;
    assign w_pop         = w_instr_valid && instr_ready;
    assign w_discard     = imem_rsp_valid && (r_drop != '0);
    assign w_fill        = imem_rsp_valid && (r_drop == '0) && (r_outst != '0);

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_pc;
    assign instr_valid    = w_instr_valid;
    assign instr_data     = r_q_data[r_head];
    assign instr_pc       = r_q_pc[r_head];

    always_comb begin
        w_occ_nxt    = r_occ;
        w_outst_nxt  = r_outst;
        w_drop_nxt   = r_drop;
        w_flush_drop = r_drop + DW'(r_outst);
        if (w_alloc && !w_pop) begin
            w_occ_nxt = r_occ + CW'(1);
        end else if (!w_alloc && w_pop) begin
            w_occ_nxt = r_occ - CW'(1);
        end
        if (w_alloc && !w_fill) begin
            w_outst_nxt = r_outst + CW'(1);
        end else if (!w_alloc && w_fill) begin
            w_outst_nxt = r_outst - CW'(1);
        end
        if (w_discard) begin
            w_drop_nxt = r_drop - DW'(1);
        end
        // A response landing in the redirect cycle is one of the owed ones
        if (imem_rsp_valid && (w_flush_drop != '0)) begin
            w_flush_drop = w_flush_drop - DW'(1);
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_pc     <= RESET_PC;
            r_filled <= '0;
            r_alloc  <= '0;
            r_fill   <= '0;
            r_head   <= '0;
            r_occ    <= '0;
            r_outst  <= '0;
            r_drop   <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                r_q_pc[i]   <= RESET_PC;
                r_q_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc;
            r_filled <= '0;
            r_alloc  <= '0;
            r_fill   <= '0;
            r_head   <= '0;
            r_occ    <= '0;
            r_outst  <= '0;
            r_drop   <= w_flush_drop;
        end else begin
            if (w_alloc) begin
                r_q_pc[r_alloc]   <= r_pc;
                r_filled[r_alloc] <= 1'b0;
                r_alloc           <= r_alloc + AW'(1);
                r_pc              <= r_pc + XLEN'(4);
            end
            if (w_fill) begin
                r_q_data[r_fill] <= imem_rsp_data;
                r_filled[r_fill] <= 1'b1;
                r_fill           <= r_fill + AW'(1);
            end
            if (w_pop) begin
                r_filled[r_head] <= 1'b0;
                r_head           <= r_head + AW'(1);
            end
            r_occ   <= w_occ_nxt;
            r_outst <= w_outst_nxt;
            r_drop  <= w_drop_nxt;
        end
    end

`ifdef PHILV_FETCH_STALL_CNT_EN
    logic [31:0] r_stall;
    logic        w_stall;

    assign w_stall      = instr_ready && !w_instr_valid && !redirect_valid;
    assign stall_cycles = r_stall;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_stall <= '0;
        end else if (w_stall && (r_stall != 32'hFFFF_FFFF)) begin
            r_stall <= r_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_philv_fetch_unit.sv
// Directed bench for philv_fetch_unit: memory model with latency,
// scoreboard of expected PCs, immediate-assertion checks.
module tb_philv_fetch_unit;

    logic        clk = 1'b0;
    logic        rstb = 1'b0;
    logic        imem_req_ready = 1'b0;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        instr_ready = 1'b0;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        instr_valid;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
`ifdef PHILV_FETCH_STALL_CNT_EN
    logic [31:0] stall_cycles;
`endif

    philv_fetch_unit #(
        .XLEN(32),
        .DEPTH(4),
        .RESET_PC(32'h0)
    ) dut (
        .clk(clk),
        .rstb(rstb),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_req_addr(imem_req_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr_data(instr_data),
        .instr_pc(instr_pc)
`ifdef PHILV_FETCH_STALL_CNT_EN
        ,
        .stall_cycles(stall_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    logic [31:0] m_pc = '0;
    int          lat = 1;
    int          cyc = 0;
    int          n_acc = 0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] expv);
        total++;
        assert (obs === expv)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (exp_q.size() == 0 && mq.size() == 0) break;
            @(negedge clk);
        end
        chk("drain", 32'(exp_q.size()), 32'd0);
    endtask

    // Memory shares rstb: reset abandons everything in flight
    always @(negedge rstb) begin
        mq.delete();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
    end

    // Handshakes are decided at the negedge and take effect at the next posedge
    always @(negedge clk) begin
        if (rstb) begin
            if (imem_rsp_valid && mq.size() > 0) void'(mq.pop_front());
            if (imem_req_valid && imem_req_ready) begin
                chk("req_addr", imem_req_addr, m_pc);
                mq.push_back('{addr: imem_req_addr, due: cyc + 1 + lat});
                exp_q.push_back(m_pc);
                m_pc = m_pc + 32'd4;
                n_acc++;
            end
            if (instr_valid && instr_ready) begin
                if (exp_q.size() == 0) begin
                    chk("sb_nonempty", 32'(exp_q.size()), 32'd1);
                end else begin
                    logic [31:0] e;
                    e = exp_q.pop_front();
                    chk("instr_pc", instr_pc, e);
                    chk("instr_data", instr_data, ~e);
                end
            end
        end
    end

    always @(posedge clk) begin
        cyc++;
        #1;
        if (rstb && mq.size() > 0 && mq[0].due <= cyc + 1) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = ~mq[0].addr;
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout total=%0d", total);
        $fatal(1, "timeout");
    end

    initial begin
        #3;
        chk("rst_req_valid", imem_req_valid, 1);
        chk("rst_req_addr", imem_req_addr, 32'h0);
        chk("rst_instr_valid", instr_valid, 0);
        chk("rst_instr_data", instr_data, 32'h0);
        chk("rst_instr_pc", instr_pc, 32'h0);

        lat = 1;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        step();
        rstb = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("first_valid_e0", instr_valid, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("stream_valid", instr_valid, 1);
        end

        step();
        rstb = 1'b0;
        exp_q.delete();
        m_pc = 32'h0;
        n_acc = 0;
        #1;
        chk("mid_rst_req_valid", imem_req_valid, 1);
        chk("mid_rst_req_addr", imem_req_addr, 32'h0);
        chk("mid_rst_instr_valid", instr_valid, 0);
        chk("mid_rst_instr_data", instr_data, 32'h0);
        chk("mid_rst_instr_pc", instr_pc, 32'h0);
`ifdef PHILV_FETCH_STALL_CNT_EN
        chk("mid_rst_stall", stall_cycles, 32'h0);
`endif
        instr_ready = 1'b0;
        step();
        rstb = 1'b1;
        repeat (8) @(negedge clk);
        chk("full_n_acc", 32'(n_acc), 32'd4);
        chk("full_req_valid", imem_req_valid, 0);
        chk("full_req_addr", imem_req_addr, 32'h10);
        chk("full_instr_valid", instr_valid, 1);
        chk("full_head_pc", instr_pc, 32'h0);
        step();
        instr_ready = 1'b1;
        repeat (10) @(negedge clk);

        step();
        imem_req_ready = 1'b0;
        wait_drain(30);
        step();
        lat = 3;
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        exp_q.delete();
        m_pc = 32'h100;
        @(negedge clk);
        chk("lat3_redir_req_valid", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("lat3_redir_addr", imem_req_addr, 32'h100);
        chk("lat3_redir_req_valid1", imem_req_valid, 1);
        step();
        imem_req_ready = 1'b1;
        repeat (12) @(negedge clk);

        step();
        imem_req_ready = 1'b0;
        wait_drain(30);
        step();
        lat = 1;
        imem_req_ready = 1'b1;
        repeat (6) @(negedge clk);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h100;
        exp_q.delete();
        m_pc = 32'h100;
        @(negedge clk);
        chk("rd_pop_instr_valid", instr_valid, 0);
        chk("rd_pop_req_valid", imem_req_valid, 0);
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("rd_pop_addr", imem_req_addr, 32'h100);
        repeat (8) @(negedge clk);

        step();
        imem_req_ready = 1'b0;
        wait_drain(30);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        exp_q.delete();
        m_pc = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk("wrap_pre_addr", imem_req_addr, 32'hFFFF_FFFC);
        step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        @(negedge clk);
        chk("wrap_addr", imem_req_addr, 32'h0);
        step();
        imem_req_ready = 1'b1;
        repeat (6) @(negedge clk);
        step();
        imem_req_ready = 1'b0;
        wait_drain(30);

`ifdef PHILV_FETCH_STALL_CNT_EN
        step();
        rstb = 1'b0;
        exp_q.delete();
        m_pc = 32'h0;
        #1;
        chk("stall_rst", stall_cycles, 32'h0);
        step();
        rstb = 1'b1;
        @(negedge clk);
        chk("stall_rel", stall_cycles, 32'h0);
        repeat (5) @(negedge clk);
        chk("stall_count5", stall_cycles, 32'd5);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
